// File: rtl/arb_pkg.sv
// Shared types for the round-robin arbiter: ownership FSM encoding and default width.
package arb_pkg;
  typedef enum logic {IDLE, OWN} arb_state_t;
  localparam int ARB_N_DEFAULT = 4;
endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: lowest requester at or above ptr, else lowest requester overall.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] id,
  output logic                 valid
);
  localparam int IW = $clog2(N);

  logic [N-1:0] masked;

  always_comb begin
    masked = '0;
    for (int i = 0; i < N; i++) masked[i] = req[i] && (i >= int'(ptr));
  end

  // Descending scans so the last hit, i.e. the lowest index, wins.
  always_comb begin
    id    = '0;
    valid = |req;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) id = IW'(i);
    if (|masked)
      for (int i = N - 1; i >= 0; i--)
        if (masked[i]) id = IW'(i);
  end
endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with held ownership, hold limit and zero-bubble handover.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEFAULT,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid
);
  localparam int IW        = $clog2(N);
  localparam int HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

  arb_state_t    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, id_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          valid_nxt;
  logic [N-1:0]  gnt_nxt;

  logic [IW-1:0] idle_id, ho_id, ho_ptr;
  logic          idle_valid, ho_valid;
  logic [N-1:0]  ho_req;
  logic          hold_hit, rel;

  // The releasing owner is removed from the handover pick so it cannot win back-to-back.
  assign ho_req   = req & ~(N'(1) << gnt_id);
  assign ho_ptr   = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
  assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HW'(HOLD_LAST));
  assign rel      = done || !req[gnt_id] || hold_hit;

  rr_pick #(.N(N)) u_pick_idle (.req(req),    .ptr(ptr),    .id(idle_id), .valid(idle_valid));
  rr_pick #(.N(N)) u_pick_ho   (.req(ho_req), .ptr(ho_ptr), .id(ho_id),   .valid(ho_valid));

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    id_nxt    = gnt_id;
    valid_nxt = gnt_valid;
    case (state)
      IDLE: begin
        if (idle_valid) begin
          state_nxt = OWN;
          id_nxt    = idle_id;
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end
      end
      OWN: begin
        if (!rel) begin
          if (hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
        end else begin
          ptr_nxt  = ho_ptr;
          hold_nxt = '0;
          if (ho_valid) begin
            id_nxt = ho_id;
          end else begin
            state_nxt = IDLE;
            id_nxt    = '0;
            valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        id_nxt    = '0;
        valid_nxt = 1'b0;
      end
    endcase
    gnt_nxt = valid_nxt ? (N'(1) << id_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt       <= gnt_nxt;
      gnt_id    <= id_nxt;
      gnt_valid <= valid_nxt;
    end
  end
endmodule
